// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and latency constant for muldiv_unit
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;

    // Cycles from the cycle start is driven to the cycle done is high.
    function automatic int done_latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO
// Multiply and divide share one 2*WIDTH accumulator and the operand-b register.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic                dz_q, dz_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                div_zero_q, div_zero_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;

    logic                op_is_div, op_signed;
    logic [WIDTH-1:0]    a_mag, b_mag;
    logic [WIDTH:0]      mul_sum;
    logic [2*WIDTH-1:0]  mul_next;
    logic [WIDTH:0]      rem_sh;
    logic                rem_ge;
    logic [WIDTH-1:0]    rem_sub;
    logic [2*WIDTH-1:0]  div_next;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo, rem, quo_fix, rem_fix;

    assign op_is_div = (op == OP_DIVU) || (op == OP_DIV);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: {remainder, dividend/quotient}; a zero divisor naturally
    // yields an all-ones quotient and the dividend as remainder.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_ge   = rem_sh >= {1'b0, opb_q};
    assign rem_sub  = rem_sh[WIDTH-1:0] - opb_q;
    assign div_next = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];
    assign quo_fix  = dz_q ? '1 : (neg_q ? (~quo + 1'b1) : quo);
    assign rem_fix  = rem_neg_q ? (~rem + 1'b1) : rem;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (start) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    acc_d      = {{WIDTH{1'b0}}, a_mag};
                    opb_d      = b_mag;
                    is_div_d   = op_is_div;
                    neg_d      = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rem_neg_d  = op_signed && a[WIDTH-1];
                    dz_d       = op_is_div && (b == '0);
                    div_zero_d = 1'b0;
                end
            end
            ST_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d       = rem_fix;
                    lo_d       = quo_fix;
                    div_zero_d = dz_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
